// File: rtl/int_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encoding, vector defaults, code width.
package int_pkg;

    localparam int unsigned NSRC_DEFAULT       = 3;
    localparam int unsigned CODE_W             = 2;
    localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0200;
    localparam logic [31:0] VEC_STRIDE_DEFAULT = 32'h0000_0040;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StEnter  = 2'd1,
        StVector = 2'd2,
        StReturn = 2'd3
    } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Priority encoder: the highest set index wins; o_valid flags a non-zero input.
module int_prio_enc #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    // Scan upward so the last (highest) set bit overrides lower ones
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_idx   = W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// Nested, prioritised interrupt sequencer: latches request edges, runs entry
// (flush, push resume PC, vector) and ERET return (pop PC, force) on the PC override path.
module int_sequencer
    import int_pkg::*;
#(
    parameter int unsigned NSRC       = NSRC_DEFAULT,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEFAULT,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
    input  logic              in_CLK,
    input  logic              in_RST,
    input  logic [NSRC-1:0]   in_IR,
    input  logic [NSRC-1:0]   int_mask,
    input  logic              ie,
    input  logic              pipe_en,
    input  logic [31:0]       resume_pc,
    input  logic              eret_wb,
    // PC override strobe (`force` is a reserved word)
    output logic              pc_force,
    output logic [31:0]       faddr,
    output logic              flush,
    output logic              ie_clr,
    output logic [NSRC-1:0]   in_service,
    output logic [NSRC-1:0]   pending,
    output logic [CODE_W-1:0] irq_code,
    output logic              busy
);

    localparam int unsigned     SP_W    = $clog2(NSRC + 1);
    localparam int unsigned     IDX_W   = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(NSRC);

    state_e            r_state;
    logic [NSRC-1:0]   r_hist;
    logic [NSRC-1:0]   r_pending;
    logic [NSRC-1:0]   r_in_service;
    logic [SP_W-1:0]   r_sp;
    logic [31:0]       r_stack [NSRC];
    logic              r_eret_pend;
    logic              r_err_uf;
    logic              r_force;
    logic              r_flush;
    logic              r_ie_clr;
    logic              r_busy;
    logic [31:0]       r_faddr;
    logic [CODE_W-1:0] r_irq_code;

    logic [NSRC-1:0]   w_edge;
    logic [NSRC-1:0]   w_elig;
    logic [CODE_W-1:0] w_cand;
    logic              w_cand_vld;
    logic [CODE_W-1:0] w_svc_idx;
    logic              w_svc_vld;
    logic [NSRC-1:0]   w_svc_clr;
    logic [CODE_W-1:0] w_next_code;
    logic [NSRC-1:0]   w_pend_clr;
    logic              w_eret_go;
    logic              w_take;
    logic [31:0]       w_vec_addr;
    logic [SP_W-1:0]   w_sp_dec;

    assign w_edge     = in_IR & ~r_hist;
    assign w_elig     = r_pending & int_mask & ~r_in_service;
    assign w_sp_dec   = r_sp - 1'b1;
    assign w_vec_addr = VEC_BASE + 32'(r_irq_code) * VEC_STRIDE;

    int_prio_enc #(.N(NSRC), .W(CODE_W)) u_enc_elig (
        .i_vec   (w_elig),
        .o_idx   (w_cand),
        .o_valid (w_cand_vld)
    );

    int_prio_enc #(.N(NSRC), .W(CODE_W)) u_enc_svc (
        .i_vec   (r_in_service),
        .o_idx   (w_svc_idx),
        .o_valid (w_svc_vld)
    );

    // A held ERET outranks any request; it only proceeds with the pipeline unlocked
    assign w_eret_go = (r_state == StIdle) && (eret_wb || r_eret_pend) && pipe_en;
    assign w_take    = (r_state == StIdle) && !w_eret_go && w_cand_vld && ie && pipe_en &&
                       (!w_svc_vld || (w_cand > w_svc_idx));

    // In-service set after dropping its top level, and the level that becomes current
    always_comb begin
        w_svc_clr = r_in_service;
        if (w_svc_vld) begin
            w_svc_clr[w_svc_idx] = 1'b0;
        end
        w_next_code = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_svc_clr[i]) begin
                w_next_code = CODE_W'(i);
            end
        end
    end

    // The entering source's pending bit is consumed while in ENTER
    always_comb begin
        w_pend_clr = '0;
        if (r_state == StEnter) begin
            w_pend_clr[r_irq_code] = 1'b1;
        end
    end

    // Edge history and pending latch; a fresh edge wins over a same-cycle clear
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            r_hist    <= '0;
            r_pending <= '0;
        end else begin
            r_hist    <= in_IR;
            r_pending <= (r_pending & ~w_pend_clr) | w_edge;
        end
    end

    // Sequencer FSM with registered PC-override outputs and the EPC stack
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            r_state      <= StIdle;
            r_in_service <= '0;
            r_sp         <= '0;
            r_eret_pend  <= 1'b0;
            r_err_uf     <= 1'b0;
            r_force      <= 1'b0;
            r_flush      <= 1'b0;
            r_ie_clr     <= 1'b0;
            r_busy       <= 1'b0;
            r_faddr      <= '0;
            r_irq_code   <= '0;
            for (int i = 0; i < NSRC; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_force  <= 1'b0;
            r_flush  <= 1'b0;
            r_ie_clr <= 1'b0;
            r_faddr  <= '0;

            if (w_eret_go) begin
                r_eret_pend <= 1'b0;
            end else if (eret_wb) begin
                r_eret_pend <= 1'b1;
            end

            unique case (r_state)
                StIdle: begin
                    if (w_eret_go) begin
                        r_state <= StReturn;
                        r_busy  <= 1'b1;
                        r_flush <= 1'b1;
                        // Empty stack: flush only, no redirect
                        if (r_sp != '0) begin
                            r_force <= 1'b1;
                            r_faddr <= r_stack[w_sp_dec[IDX_W-1:0]];
                        end
                    end else if (w_take) begin
                        r_state    <= StEnter;
                        r_busy     <= 1'b1;
                        r_irq_code <= w_cand;
                        r_flush    <= 1'b1;
                        r_ie_clr   <= 1'b1;
                    end
                end
                StEnter: begin
                    r_stack[r_sp[IDX_W-1:0]] <= resume_pc;
                    r_sp                     <= r_sp + 1'b1;
                    r_state                  <= StVector;
                    r_force                  <= 1'b1;
                    r_faddr                  <= w_vec_addr;
                end
                StVector: begin
                    r_in_service[r_irq_code] <= 1'b1;
                    r_state                  <= StIdle;
                    r_busy                   <= 1'b0;
                end
                StReturn: begin
                    if (r_sp == '0) begin
                        r_err_uf <= 1'b1;
                    end else begin
                        r_sp <= w_sp_dec;
                    end
                    r_in_service <= w_svc_clr;
                    r_irq_code   <= w_next_code;
                    r_state      <= StIdle;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A push into a full stack means the priority rule was bypassed
    assert property (@(posedge in_CLK) disable iff (in_RST)
        !((r_state == StEnter) && (r_sp == SP_FULL)));

    cover property (@(posedge in_CLK) r_err_uf);

    assign pc_force   = r_force;
    assign faddr      = r_faddr;
    assign flush      = r_flush;
    assign ie_clr     = r_ie_clr;
    assign in_service = r_in_service;
    assign pending    = r_pending;
    assign irq_code   = r_irq_code;
    assign busy       = r_busy;

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench: a source/stack model predicts override events; a monitor checks them.
module tb_int_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  in_IR;
    logic [2:0]  int_mask;
    logic        ie;
    logic        pipe_en;
    logic [31:0] resume_pc;
    logic        eret_wb;
    logic        pc_force;
    logic [31:0] faddr;
    logic        flush;
    logic        ie_clr;
    logic [2:0]  in_service;
    logic [2:0]  pending;
    logic [1:0]  irq_code;
    logic        busy;

    int_sequencer u_dut (
        .in_CLK     (clk),
        .in_RST     (rst),
        .in_IR      (in_IR),
        .int_mask   (int_mask),
        .ie         (ie),
        .pipe_en    (pipe_en),
        .resume_pc  (resume_pc),
        .eret_wb    (eret_wb),
        .pc_force   (pc_force),
        .faddr      (faddr),
        .flush      (flush),
        .ie_clr     (ie_clr),
        .in_service (in_service),
        .pending    (pending),
        .irq_code   (irq_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic        ic;
        logic        fo;
        logic [31:0] fa;
        logic [1:0]  cd;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_a;
    ev_t         mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Model: pending set, stack of serviced sources and their resume PCs
    logic [2:0]  m_pend;
    int          m_svc[$];
    logic [31:0] m_pc[$];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endfunction

    function automatic int hi_idx(input logic [2:0] v);
        int r = -1;
        for (int i = 0; i < 3; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [2:0] svc_bits();
        logic [2:0] b = 3'b000;
        foreach (m_svc[i]) b[m_svc[i]] = 1'b1;
        return b;
    endfunction

    function automatic void m_reset();
        m_pend = 3'b000;
        m_svc.delete();
        m_pc.delete();
    endfunction

    // Take the best eligible request if it outranks everything in service
    function automatic void m_cascade();
        int c;
        if (!ie || !pipe_en) return;
        c = hi_idx(m_pend & int_mask & ~svc_bits());
        if (c < 0) return;
        if (m_svc.size() > 0 && c <= m_svc[$]) return;
        exp_q.push_back('{fl: 1'b1, ic: 1'b1, fo: 1'b0, fa: 32'h0, cd: 2'(c)});
        exp_q.push_back('{fl: 1'b0, ic: 1'b0, fo: 1'b1,
                          fa: 32'h200 + 32'(c) * 32'h40, cd: 2'(c)});
        m_pend[c] = 1'b0;
        m_svc.push_back(c);
        m_pc.push_back(resume_pc);
    endfunction

    function automatic void m_eret();
        if (m_svc.size() == 0) begin
            exp_q.push_back('{fl: 1'b1, ic: 1'b0, fo: 1'b0, fa: 32'h0, cd: 2'd0});
        end else begin
            exp_q.push_back('{fl: 1'b1, ic: 1'b0, fo: 1'b1, fa: m_pc[$], cd: 2'(m_svc[$])});
            void'(m_svc.pop_back());
            void'(m_pc.pop_back());
        end
    endfunction

    // Monitor: every override/flush cycle must match the next predicted event
    always @(negedge clk) begin
        if (!rst && (flush || pc_force || ie_clr)) begin
            mon_a = '{fl: flush, ic: ie_clr, fo: pc_force, fa: faddr, cd: irq_code};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got fl=%b ic=%b fo=%b fa=%h cd=%0d, none due",
                         mon_a.fl, mon_a.ic, mon_a.fo, mon_a.fa, mon_a.cd);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    n_bad++;
                    $display("FAIL event: got fl=%b ic=%b fo=%b fa=%h cd=%0d want fl=%b ic=%b fo=%b fa=%h cd=%0d",
                             mon_a.fl, mon_a.ic, mon_a.fo, mon_a.fa, mon_a.cd,
                             mon_e.fl, mon_e.ic, mon_e.fo, mon_e.fa, mon_e.cd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (10) tick();
        chk("pending", 32'(pending), 32'(m_pend));
        chk("in_service", 32'(in_service), 32'(svc_bits()));
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic op_pulse(input logic [2:0] bits);
        m_pend |= bits;
        m_cascade();
        in_IR = bits;
        tick();
        in_IR = 3'b000;
        settle();
    endtask

    task automatic op_double(input logic [2:0] a, input logic [2:0] b, input int gap);
        m_pend |= a;
        m_cascade();
        in_IR = a;
        tick();
        in_IR = 3'b000;
        repeat (gap - 1) tick();
        m_pend |= b;
        m_cascade();
        in_IR = b;
        tick();
        in_IR = 3'b000;
        settle();
    endtask

    task automatic op_eret();
        m_eret();
        m_cascade();
        eret_wb = 1'b1;
        tick();
        eret_wb = 1'b0;
        settle();
    endtask

    task automatic op_eret_ir(input logic [2:0] bits);
        m_eret();
        m_pend |= bits;
        m_cascade();
        eret_wb = 1'b1;
        in_IR   = bits;
        tick();
        eret_wb = 1'b0;
        in_IR   = 3'b000;
        settle();
    endtask

    task automatic op_mask(input logic [2:0] m);
        int_mask = m;
        m_cascade();
        settle();
    endtask

    task automatic op_ie(input logic v);
        ie = v;
        m_cascade();
        settle();
    endtask

    task automatic op_stall(input logic [2:0] bits, input int n, input logic with_eret);
        pipe_en = 1'b0;
        m_pend |= bits;
        in_IR = bits;
        tick();
        in_IR = 3'b000;
        if (with_eret) begin
            eret_wb = 1'b1;
            tick();
            eret_wb = 1'b0;
        end
        repeat (n) tick();
        chk("stall_pending", 32'(pending), 32'(m_pend));
        pipe_en = 1'b1;
        if (with_eret) m_eret();
        m_cascade();
        settle();
    endtask

    task automatic op_pipe_drop(input logic [2:0] bits);
        m_pend |= bits;
        m_cascade();
        in_IR = bits;
        tick();
        in_IR = 3'b000;
        tick();
        pipe_en = 1'b0;
        repeat (3) tick();
        pipe_en = 1'b1;
        m_cascade();
        settle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        in_IR     = 3'b000;
        int_mask  = 3'b000;
        ie        = 1'b0;
        pipe_en   = 1'b1;
        eret_wb   = 1'b0;
        resume_pc = 32'h0;
        m_reset();

        #1 rst = 1'b1;
        #1;
        chk("rst_force", 32'(pc_force), 32'd0);
        chk("rst_faddr", faddr, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_ie_clr", 32'(ie_clr), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_irq_code", 32'(irq_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset landing in VECTOR clears outputs at once
        int_mask  = 3'b111;
        ie        = 1'b1;
        resume_pc = 32'h100;
        m_pend |= 3'b100;
        m_cascade();
        in_IR = 3'b100;
        tick();
        in_IR = 3'b000;
        tick();
        tick();
        chk("vector_force", 32'(pc_force), 32'd1);
        chk("pre_rst_queue", 32'(exp_q.size()), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_force", 32'(pc_force), 32'd0);
        chk("midrst_flush", 32'(flush), 32'd0);
        chk("midrst_in_service", 32'(in_service), 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        exp_q.delete();
        m_reset();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Directed scenarios
        resume_pc = 32'h40;
        op_pulse(3'b001);
        resume_pc = 32'h208;
        op_pulse(3'b100);
        op_eret();
        op_eret();
        op_pulse(3'b100);
        op_pulse(3'b010);
        op_eret();
        op_eret_ir(3'b001);
        op_eret();
        op_stall(3'b010, 5, 1'b0);
        op_eret();
        op_mask(3'b101);
        op_pulse(3'b010);
        op_mask(3'b111);
        op_eret();
        op_eret();
        op_pipe_drop(3'b100);
        op_eret();
        op_stall(3'b001, 3, 1'b1);

        // Randomised traffic
        for (int k = 0; k < 150; k++) begin
            resume_pc = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 9))
                0, 1: op_pulse(3'($urandom_range(1, 7)));
                2, 3: op_eret();
                4:    op_mask(3'($urandom_range(0, 7)));
                5:    op_ie($urandom_range(0, 3) != 0);
                6:    op_stall(3'($urandom_range(0, 7)), int'($urandom_range(1, 5)),
                               $urandom_range(0, 1) == 1);
                7:    op_double(3'($urandom_range(1, 7)), 3'($urandom_range(1, 7)),
                                int'($urandom_range(2, 3)));
                8:    op_pipe_drop(3'($urandom_range(1, 7)));
                default: op_eret_ir(3'($urandom_range(1, 7)));
            endcase
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
